alu_sequencer: RTL and testbench

ALU_SEQUENCER -- requirements
Module: alu_sequencer

---
 rtl/alu_seq_pkg.sv | 40 ++++
 rtl/alu_seq_if.sv | 26 ++
 rtl/alu_seq_regfile.sv | 38 +++
 rtl/alu_sequencer.sv | 127 ++++++++++++
 tb/tb_alu_sequencer.sv | 248 ++++++++++++++++++++++++
 5 files changed

// File: rtl/alu_seq_pkg.sv
// Shared constants for the ALU sequencer: op codes, FSM states, instruction field positions.
package alu_seq_pkg;

  localparam int INSTR_W     = 17;
  localparam int IMM_SEL_POS = 16;
  localparam int OP_MSB      = 15;
  localparam int OP_LSB      = 12;
  localparam int RD_MSB      = 11;
  localparam int RD_LSB      = 10;
  localparam int RS_MSB      = 9;
  localparam int RS_LSB      = 8;
  localparam int IMM_MSB     = 7;
  localparam int IMM_LSB     = 0;

  localparam logic [3:0] OP_ADD        = 4'd0;
  localparam logic [3:0] OP_SUB        = 4'd1;
  localparam logic [3:0] OP_AND        = 4'd2;
  localparam logic [3:0] OP_OR         = 4'd3;
  localparam logic [3:0] OP_XOR        = 4'd4;
  localparam logic [3:0] OP_NOT        = 4'd5;
  localparam logic [3:0] OP_INC        = 4'd6;
  localparam logic [3:0] OP_DEC        = 4'd7;
  localparam logic [3:0] OP_SHL        = 4'd8;
  localparam logic [3:0] OP_SHR        = 4'd9;
  localparam logic [3:0] OP_ASR        = 4'd10;
  localparam logic [3:0] OP_ROL        = 4'd11;
  localparam logic [3:0] OP_ROR        = 4'd12;
  localparam logic [3:0] OP_LAST_LEGAL = 4'd12;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_EXEC = 2'd1,
    ST_WB   = 2'd2
  } state_t;

  function automatic logic op_is_legal(input logic [3:0] op);
    return op <= OP_LAST_LEGAL;
  endfunction

endpackage

// File: rtl/alu_seq_if.sv
// Instruction handshake, external ALU drive/return and retire outputs of the ALU sequencer.
interface alu_seq_if;
  logic [16:0] instr;
  logic        instr_valid;
  logic        instr_ready;
  logic [7:0]  alu_opcode;
  logic [7:0]  alu_a;
  logic [7:0]  alu_b;
  logic [7:0]  alu_result;
  logic        alu_c;
  logic        alu_v;
  logic        done;
  logic [7:0]  wb_data;
  logic [3:0]  flags;
  logic        illegal;

  modport master (
    output instr, instr_valid, alu_result, alu_c, alu_v,
    input  instr_ready, alu_opcode, alu_a, alu_b, done, wb_data, flags, illegal
  );

  modport slave (
    input  instr, instr_valid, alu_result, alu_c, alu_v,
    output instr_ready, alu_opcode, alu_a, alu_b, done, wb_data, flags, illegal
  );
endinterface

// File: rtl/alu_seq_regfile.sv
// 4x8 register file: one synchronous write port, two operand read ports, optional
// combinational debug read port when ALU_SEQ_DBG_PORT_EN is defined.
module alu_seq_regfile #(
  parameter logic [7:0] REG_INIT = 8'h00
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       we,
  input  logic [1:0] waddr,
  input  logic [7:0] wdata,
  input  logic [1:0] raddr_a,
  input  logic [1:0] raddr_b,
  output logic [7:0] rdata_a,
  output logic [7:0] rdata_b
`ifdef ALU_SEQ_DBG_PORT_EN
  ,
  input  logic [1:0] raddr_dbg,
  output logic [7:0] rdata_dbg
`endif
);

  logic [7:0] regs [4];

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < 4; i++) regs[i] <= REG_INIT;
    end else if (we) begin
      regs[waddr] <= wdata;
    end
  end

  assign rdata_a = regs[raddr_a];
  assign rdata_b = regs[raddr_b];
`ifdef ALU_SEQ_DBG_PORT_EN
  assign rdata_dbg = regs[raddr_dbg];
`endif

endmodule

// File: rtl/alu_sequencer.sv
// Three-cycle IDLE/EXEC/WB sequencer driving an external combinational ALU into a 4x8 register file.
// Optional debug read port enabled by defining ALU_SEQ_DBG_PORT_EN.
module alu_sequencer
  import alu_seq_pkg::*;
#(
  parameter logic [7:0] REG_INIT = 8'h00
) (
  input  logic       clk,
  input  logic       rst,
  alu_seq_if.slave   bus
`ifdef ALU_SEQ_DBG_PORT_EN
  ,
  input  logic [1:0] dbg_sel,
  output logic [7:0] dbg_data
`endif
);

  state_t     state, state_nxt;
  logic       accept, sample, retire;
  logic [7:0] opcode_q, a_q, b_q, res_q, wb_q;
  logic [1:0] rd_q;
  logic       legal_q, c_q, v_q, done_q, illegal_q;
  logic [3:0] flags_q;
  logic [7:0] rdata_a, rdata_b;

  wire        imm_sel = bus.instr[IMM_SEL_POS];
  wire  [3:0] op      = bus.instr[OP_MSB:OP_LSB];
  wire  [1:0] rd      = bus.instr[RD_MSB:RD_LSB];
  wire  [1:0] rs      = bus.instr[RS_MSB:RS_LSB];
  wire  [7:0] imm     = bus.instr[IMM_MSB:IMM_LSB];

  alu_seq_regfile #(.REG_INIT(REG_INIT)) u_regfile (
    .clk       (clk),
    .rst       (rst),
    .we        (retire && legal_q),
    .waddr     (rd_q),
    .wdata     (res_q),
    .raddr_a   (rd),
    .raddr_b   (rs),
    .rdata_a   (rdata_a),
    .rdata_b   (rdata_b)
`ifdef ALU_SEQ_DBG_PORT_EN
    ,
    .raddr_dbg (dbg_sel),
    .rdata_dbg (dbg_data)
`endif
  );

  always_ff @(posedge clk) begin
    if (rst) state <= ST_IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    accept    = 1'b0;
    sample    = 1'b0;
    retire    = 1'b0;
    case (state)
      ST_IDLE: if (bus.instr_valid) begin
        accept    = 1'b1;
        state_nxt = ST_EXEC;
      end
      ST_EXEC: begin
        sample    = 1'b1;
        state_nxt = ST_WB;
      end
      ST_WB: begin
        retire    = 1'b1;
        state_nxt = ST_IDLE;
      end
      default: state_nxt = ST_IDLE;
    endcase
  end

  // Reset clears everything in flight, so an aborted instruction never retires.
  always_ff @(posedge clk) begin
    if (rst) begin
      opcode_q  <= 8'h00;
      a_q       <= 8'h00;
      b_q       <= 8'h00;
      rd_q      <= 2'd0;
      legal_q   <= 1'b0;
      res_q     <= 8'h00;
      c_q       <= 1'b0;
      v_q       <= 1'b0;
      flags_q   <= 4'h0;
      wb_q      <= 8'h00;
      done_q    <= 1'b0;
      illegal_q <= 1'b0;
    end else begin
      done_q    <= 1'b0;
      illegal_q <= 1'b0;
      if (accept) begin
        opcode_q <= {4'h0, op};
        a_q      <= rdata_a;
        b_q      <= imm_sel ? imm : rdata_b;
        rd_q     <= rd;
        legal_q  <= op_is_legal(op);
      end
      if (sample) begin
        res_q <= bus.alu_result;
        c_q   <= bus.alu_c;
        v_q   <= bus.alu_v;
      end
      if (retire) begin
        if (legal_q) begin
          flags_q <= {res_q[7], (res_q == 8'h00), c_q, v_q};
          wb_q    <= res_q;
          done_q  <= 1'b1;
        end else begin
          illegal_q <= 1'b1;
        end
      end
    end
  end

  assign bus.instr_ready = (state == ST_IDLE);
  assign bus.alu_opcode  = opcode_q;
  assign bus.alu_a       = a_q;
  assign bus.alu_b       = b_q;
  assign bus.done        = done_q;
  assign bus.wb_data     = wb_q;
  assign bus.flags       = flags_q;
  assign bus.illegal     = illegal_q;

endmodule

// File: tb/tb_alu_sequencer.sv
// Scoreboard bench for alu_sequencer: behavioural ALU and register model, directed cases then random traffic.
`timescale 1ns/1ps
module tb_alu_sequencer;
  import alu_seq_pkg::*;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  alu_seq_if bus ();

`ifdef ALU_SEQ_DBG_PORT_EN
  logic [1:0] dbg_sel = 2'd0;
  logic [7:0] dbg_data;
`endif

  alu_sequencer #(.REG_INIT(8'h00)) dut (
    .clk      (clk),
    .rst      (rst),
    .bus      (bus)
`ifdef ALU_SEQ_DBG_PORT_EN
    ,
    .dbg_sel  (dbg_sel),
    .dbg_data (dbg_data)
`endif
  );

  typedef struct packed {
    logic       ill;
    logic [7:0] wb;
    logic [3:0] fl;
  } exp_t;

  int         n_chk  = 0;
  int         n_pass = 0;
  exp_t       sb[$];
  logic [7:0] mreg [4];
  logic [3:0] mflags;
  logic [7:0] last_a, last_b;
  logic [3:0] last_op;

  task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, act, exp);
  endtask

  // Returns {c, v, result}.
  function automatic logic [9:0] alu_model(input logic [3:0] op, input logic [7:0] a, input logic [7:0] b);
    logic [8:0] t;
    logic [7:0] r;
    logic       c, v;
    r = 8'h00; c = 1'b0; v = 1'b0;
    case (op)
      OP_ADD: begin t = {1'b0, a} + {1'b0, b}; r = t[7:0]; c = t[8]; v = (a[7] == b[7]) && (r[7] != a[7]); end
      OP_SUB: begin t = {1'b0, a} - {1'b0, b}; r = t[7:0]; c = t[8]; v = (a[7] != b[7]) && (r[7] != a[7]); end
      OP_AND: r = a & b;
      OP_OR:  r = a | b;
      OP_XOR: r = a ^ b;
      OP_NOT: r = ~a;
      OP_INC: begin t = {1'b0, a} + 9'd1; r = t[7:0]; c = t[8]; v = (a == 8'h7F); end
      OP_DEC: begin r = a - 8'd1; c = (a == 8'h00); v = (a == 8'h80); end
      OP_SHL: begin r = {a[6:0], 1'b0}; c = a[7]; end
      OP_SHR: begin r = {1'b0, a[7:1]}; c = a[0]; end
      OP_ASR: begin r = {a[7], a[7:1]}; c = a[0]; end
      OP_ROL: begin r = {a[6:0], a[7]}; c = a[7]; end
      OP_ROR: begin r = {a[0], a[7:1]}; c = a[0]; end
      default: r = 8'h00;
    endcase
    return {c, v, r};
  endfunction

  always_comb begin
    logic [9:0] m;
    m = alu_model(bus.alu_opcode[3:0], bus.alu_a, bus.alu_b);
    bus.alu_c      = m[9];
    bus.alu_v      = m[8];
    bus.alu_result = m[7:0];
  end

  function automatic logic [16:0] mk(input logic s, input logic [3:0] op, input logic [1:0] rd,
                                     input logic [1:0] rs, input logic [7:0] imm);
    return {s, op, rd, rs, imm};
  endfunction

  task automatic predict(input logic [16:0] ins, input bit push);
    logic [9:0] m;
    exp_t       e;
    last_op = ins[15:12];
    last_a  = mreg[ins[11:10]];
    last_b  = ins[16] ? ins[7:0] : mreg[ins[9:8]];
    if (!push) return;
    if (last_op <= OP_LAST_LEGAL) begin
      m = alu_model(last_op, last_a, last_b);
      mreg[ins[11:10]] = m[7:0];
      mflags = {m[7], (m[7:0] == 8'h00), m[9], m[8]};
      e = '{ill: 1'b0, wb: m[7:0], fl: mflags};
    end else begin
      e = '{ill: 1'b1, wb: 8'h00, fl: mflags};
    end
    sb.push_back(e);
  endtask

  // Call at a negedge; holds valid until accepted, returns at posedge+1 of the transfer.
  task automatic issue(input logic [16:0] ins, input bit retire, output int waited);
    bus.instr       = ins;
    bus.instr_valid = 1'b1;
    waited = 0;
    while (!bus.instr_ready && waited < 20) begin
      @(negedge clk);
      waited++;
    end
    if (!bus.instr_ready) begin
      check_eq("issue_timeout", 32'd0, 32'd1);
      bus.instr_valid = 1'b0;
      return;
    end
    predict(ins, retire);
    @(posedge clk);
    #1 bus.instr_valid = 1'b0;
  endtask

  task automatic run(input logic [16:0] ins);
    int w;
    issue(ins, 1'b1, w);
    repeat (3) @(negedge clk);
  endtask

  task automatic exec_check(input string tag);
    @(negedge clk);
    check_eq({tag, "_alu_a"}, bus.alu_a, last_a);
    check_eq({tag, "_alu_b"}, bus.alu_b, last_b);
    check_eq({tag, "_opcode"}, bus.alu_opcode, {4'h0, last_op});
  endtask

  task automatic model_reset();
    for (int i = 0; i < 4; i++) mreg[i] = 8'h00;
    mflags = 4'h0;
    sb.delete();
  endtask

  always @(negedge clk) begin
    exp_t e;
    if (!rst && (bus.done || bus.illegal)) begin
      if (sb.size() == 0) begin
        check_eq("unexpected_retire", {30'd0, bus.done, bus.illegal}, 32'd0);
      end else begin
        e = sb.pop_front();
        check_eq("retire_kind", {30'd0, bus.done, bus.illegal}, e.ill ? 32'd1 : 32'd2);
        check_eq("flags", {28'd0, bus.flags}, {28'd0, e.fl});
        if (!e.ill) check_eq("wb_data", {24'd0, bus.wb_data}, {24'd0, e.wb});
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int w;
    bus.instr       = '0;
    bus.instr_valid = 1'b0;
    rst             = 1'b1;
    model_reset();
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    check_eq("rst_ready", bus.instr_ready, 1);
    check_eq("rst_done", bus.done, 0);
    check_eq("rst_illegal", bus.illegal, 0);
    check_eq("rst_flags", bus.flags, 0);
    check_eq("rst_opcode", bus.alu_opcode, 0);
    check_eq("rst_alu_a", bus.alu_a, 0);
    check_eq("rst_alu_b", bus.alu_b, 0);
    check_eq("rst_wb_data", bus.wb_data, 0);

    // First instruction: operands in EXEC, done exactly in the cycle after edge 2.
    issue(mk(1'b1, OP_ADD, 2'd0, 2'd0, 8'h7F), 1'b1, w);
    exec_check("add7f");
    check_eq("exec_ready_low", bus.instr_ready, 0);
    @(negedge clk);
    check_eq("wb_no_done_yet", bus.done, 0);
    @(negedge clk);
    check_eq("lat_done", bus.done, 1);
    check_eq("lat_ready_back", bus.instr_ready, 1);

    run(mk(1'b1, OP_ADD, 2'd0, 2'd0, 8'h01));   // 7F+01: N=1 V=1

    run(mk(1'b1, OP_ADD, 2'd1, 2'd1, 8'h05));
    run(mk(1'b1, OP_ADD, 2'd2, 2'd2, 8'h05));
    run(mk(1'b0, OP_SUB, 2'd1, 2'd2, 8'h00));   // Z=1
    issue(mk(1'b0, OP_ADD, 2'd1, 2'd1, 8'h00), 1'b1, w);
    exec_check("b2b_rd_eq_rs");
    repeat (2) @(negedge clk);

    // Valid held through EXEC/WB of the prior instruction is only taken in IDLE.
    issue(mk(1'b1, OP_ADD, 2'd2, 2'd2, 8'h03), 1'b1, w);
    @(negedge clk);
    issue(mk(1'b0, OP_ADD, 2'd2, 2'd2, 8'h00), 1'b1, w);
    check_eq("hold_wait_cycles", w, 2);
    exec_check("hold_sees_write");
    repeat (2) @(negedge clk);

    issue(mk(1'b0, 4'hE, 2'd0, 2'd1, 8'h00), 1'b1, w);
    @(negedge clk);
    check_eq("ill_exec_ready", bus.instr_ready, 0);
    @(negedge clk);
    check_eq("ill_wb_ready", bus.instr_ready, 0);
    @(negedge clk);
    check_eq("ill_ready_back", bus.instr_ready, 1);
    check_eq("ill_no_done", bus.done, 0);
    run(mk(1'b1, OP_ADD, 2'd0, 2'd0, 8'h00));   // R0 still 80

    // Reset during EXEC aborts the instruction; valid during reset is ignored.
    run(mk(1'b1, OP_ADD, 2'd3, 2'd3, 8'h42));
    issue(mk(1'b1, OP_INC, 2'd3, 2'd0, 8'hFF), 1'b0, w);
    @(negedge clk);
    rst             = 1'b1;
    bus.instr       = mk(1'b1, OP_XOR, 2'd1, 2'd0, 8'hA5);
    bus.instr_valid = 1'b1;
    @(negedge clk);
    rst             = 1'b0;
    bus.instr_valid = 1'b0;
    model_reset();
    check_eq("abort_ready", bus.instr_ready, 1);
    check_eq("abort_opcode", bus.alu_opcode, 0);
    check_eq("abort_alu_b", bus.alu_b, 0);
    check_eq("abort_flags", bus.flags, 0);
    check_eq("abort_done", bus.done, 0);
    repeat (3) @(negedge clk);
    run(mk(1'b1, OP_ADD, 2'd3, 2'd3, 8'h00));   // R3 back to REG_INIT
    run(mk(1'b1, OP_OR, 2'd0, 2'd0, 8'h00));

    for (int i = 0; i < 40; i++) begin
      run(mk(1'($urandom_range(0, 1)), 4'($urandom_range(0, 15)), 2'($urandom_range(0, 3)),
             2'($urandom_range(0, 3)), 8'($urandom_range(0, 255))));
    end

    repeat (4) @(negedge clk);
    check_eq("sb_drained", sb.size(), 0);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
